if_stage: RTL and testbench

IF_STAGE -- requirements
Module: if_stage

---
 rtl/if_stage.sv | 191 +++++++++++++++++++
 tb/tb_if_stage.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
`default_nettype none
// ============================================================================
//  Module   : if_stage
//  Purpose  : Instruction fetch stage. Issues word-aligned requests to the
//             instruction memory, buffers in-order responses as {pc, instr}
//             pairs and presents them to decode. Handles decode back-pressure
//             and redirects (taken branches/jumps), dropping responses that
//             belong to requests issued before the redirect.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    BOOT_ADDR         first fetch address after reset
//    FIFO_DEPTH        fetch buffer entries (2 or 4)
//  Ports
//    clk_i             clock, all state on rising edge
//    rst_n_i           asynchronous active-low reset
//    instr_req_o       memory request
//    instr_addr_o      request address (word aligned)
//    instr_gnt_i       request accepted this cycle
//    instr_rvalid_i    in-order response valid
//    instr_rdata_i     response instruction word
//    pc_if_o           PC of the presented instruction
//    instr_if_o        presented instruction (NOP when not valid)
//    valid_if_o        pc_if_o / instr_if_o valid
//    stall_if_i        decode cannot accept
//    redirect_i        restart fetch at redirect_target_i
//    redirect_target_i redirect address (bits [1:0] ignored)
//  Configuration macro
//    IF_BYPASS_EN      present a response in its arrival cycle when the
//                      buffer is empty and decode is ready
// ============================================================================
module if_stage #(
    parameter logic [31:0] BOOT_ADDR  = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    output logic        instr_req_o,
    output logic [31:0] instr_addr_o,
    input  logic        instr_gnt_i,
    input  logic        instr_rvalid_i,
    input  logic [31:0] instr_rdata_i,
    output logic [31:0] pc_if_o,
    output logic [31:0] instr_if_o,
    output logic        valid_if_o,
    input  logic        stall_if_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_target_i
);

    localparam int          PTR_W     = (FIFO_DEPTH > 2) ? 2 : 1;
    localparam int          CNT_W     = PTR_W + 1;
    localparam int          OCC_W     = CNT_W + 1;
    localparam logic [OCC_W-1:0] DEPTH_OCC = OCC_W'(FIFO_DEPTH);
    localparam logic [31:0] NOP       = 32'h0000_0013;

    typedef enum logic [1:0] {
        RESET_WAIT = 2'd0,
        FETCH      = 2'd1,
        DISCARD    = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [31:0]      fetch_pc, last_pc;
    logic [31:0]      fifo_pc    [FIFO_DEPTH];
    logic [31:0]      fifo_instr [FIFO_DEPTH];
    logic [31:0]      pcq        [FIFO_DEPTH];  // addresses of outstanding requests
    logic [PTR_W-1:0] rd_ptr, wr_ptr, pcq_rd, pcq_wr;
    logic [CNT_W-1:0] count, outstanding, discard;
    logic [CNT_W-1:0] outstanding_nxt, discard_nxt;
    logic [OCC_W-1:0] occupancy;
    logic             active, grant, resp, resp_live, bypass, push, pop, fifo_empty;

    assign active     = (state != RESET_WAIT);
    assign fifo_empty = (count == '0);

    // Outstanding requests already own a buffer slot, so the sum bounds the
    // buffer fill and a push can never meet a full buffer without a pop.
    assign occupancy    = {1'b0, outstanding} + {1'b0, count};
    assign instr_req_o  = active && !redirect_i && (occupancy < DEPTH_OCC);
    assign instr_addr_o = fetch_pc;

    assign grant     = instr_req_o && instr_gnt_i;
    assign resp      = active && instr_rvalid_i;
    // A response is kept only if it is not stale and no redirect kills it now.
    assign resp_live = resp && (discard == '0) && !redirect_i;

`ifdef IF_BYPASS_EN
    assign bypass = resp_live && fifo_empty && !stall_if_i;
`else
    assign bypass = 1'b0;
`endif

    assign push       = resp_live && !bypass;
    assign pop        = !fifo_empty && !redirect_i && !stall_if_i;
    assign valid_if_o = (!fifo_empty || bypass) && !redirect_i;

    always_comb begin
        pc_if_o    = last_pc;
        instr_if_o = NOP;
        if (bypass) begin
            pc_if_o    = pcq[pcq_rd];
            instr_if_o = instr_rdata_i;
        end else if (valid_if_o) begin
            pc_if_o    = fifo_pc[rd_ptr];
            instr_if_o = fifo_instr[rd_ptr];
        end
    end

    assign outstanding_nxt = outstanding + CNT_W'(grant) - CNT_W'(resp);

    // After a redirect every request still in flight is stale, including
    // those already marked for discard, so the counter takes the full count.
    always_comb begin
        discard_nxt = discard;
        if (redirect_i) begin
            discard_nxt = outstanding_nxt;
        end else if (resp && (discard != '0)) begin
            discard_nxt = discard - 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            RESET_WAIT: state_nxt = FETCH;
            FETCH:      if (redirect_i && (outstanding_nxt != '0)) state_nxt = DISCARD;
            DISCARD:    if (discard_nxt == '0) state_nxt = FETCH;
            default:    state_nxt = RESET_WAIT;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state       <= RESET_WAIT;
            fetch_pc    <= BOOT_ADDR & 32'hFFFF_FFFC;
            last_pc     <= 32'h0000_0000;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            pcq_rd      <= '0;
            pcq_wr      <= '0;
            count       <= '0;
            outstanding <= '0;
            discard     <= '0;
        end else begin
            state       <= state_nxt;
            outstanding <= outstanding_nxt;
            discard     <= discard_nxt;

            if (redirect_i) begin
                fetch_pc <= redirect_target_i & 32'hFFFF_FFFC;
            end else if (grant) begin
                fetch_pc <= fetch_pc + 32'd4;
            end

            if (valid_if_o) begin
                last_pc <= pc_if_o;
            end

            if (grant) begin
                pcq_wr <= pcq_wr + 1'b1;
            end
            if (resp) begin
                pcq_rd <= pcq_rd + 1'b1;
            end

            if (redirect_i) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop)  rd_ptr <= rd_ptr + 1'b1;
                count <= count + CNT_W'(push) - CNT_W'(pop);
            end
        end
    end

    // Storage needs no reset: entries are only read once marked valid.
    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_pc[wr_ptr]    <= pcq[pcq_rd];
            fifo_instr[wr_ptr] <= instr_rdata_i;
        end
        if (grant) begin
            pcq[pcq_wr] <= fetch_pc;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_if_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_if_stage
//  Purpose  : Directed and constrained-random bench for if_stage with an
//             in-order instruction memory model and a PC sequence model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_if_stage;

    localparam int          DEPTH = 2;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic        clk, rst_n;
    logic        instr_req, instr_gnt, instr_rvalid, valid_if, stall_if, redirect;
    logic [31:0] instr_addr, instr_rdata, pc_if, instr_if, redirect_target;

    if_stage #(
        .BOOT_ADDR (32'h0000_0000),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk_i            (clk),
        .rst_n_i          (rst_n),
        .instr_req_o      (instr_req),
        .instr_addr_o     (instr_addr),
        .instr_gnt_i      (instr_gnt),
        .instr_rvalid_i   (instr_rvalid),
        .instr_rdata_i    (instr_rdata),
        .pc_if_o          (pc_if),
        .instr_if_o       (instr_if),
        .valid_if_o       (valid_if),
        .stall_if_i       (stall_if),
        .redirect_i       (redirect),
        .redirect_target_i(redirect_target)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          ready;
    } mreq_t;

    mreq_t       memq[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc_n = 0, last_ready = 0, lat_min = 1, lat_max = 1, gnt_pct = 100;
    int          resp_total = 0, cons_total = 0;
    bit          drv_rst_n = 0, drv_stall = 0, drv_redirect = 0;
    logic [31:0] drv_target = 32'h0;
    logic [31:0] exp_pc = 32'h0;
    bit          prev_req = 0, prev_gnt = 0;
    logic [31:0] prev_addr = 32'h0;
    logic [31:0] grant_log[$];
    logic [31:0] cons_log[$];
    bit          consumed_now = 0;
    logic [31:0] consumed_pc = 32'h0;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc_n);
        end
    endtask

    // One clock cycle: drive inputs at the falling edge, observe 1 time unit
    // later, then update the memory model and the expected PC sequence.
    task automatic cyc();
        int lat, rdy;
        @(negedge clk);
        cyc_n++;
        rst_n           = drv_rst_n;
        stall_if        = drv_stall;
        redirect        = drv_redirect;
        redirect_target = drv_target;
        instr_gnt       = (gnt_pct >= 100) || ($urandom_range(0, 99) < gnt_pct);
        if (!drv_rst_n) begin
            memq.delete();
            last_ready = 0;
        end
        if (memq.size() > 0 && memq[0].ready <= cyc_n) begin
            instr_rvalid = 1'b1;
            instr_rdata  = memf(memq[0].addr);
        end else begin
            instr_rvalid = 1'b0;
            instr_rdata  = 32'hBAD0_0BAD;
        end
        #1;
        consumed_now = 0;
        if (!drv_rst_n) begin
            exp_pc     = 32'h0;
            prev_req   = 0;
            prev_gnt   = 0;
            resp_total = 0;
            cons_total = 0;
            return;
        end
        if (prev_req && !prev_gnt) chk("addr_hold", instr_addr, prev_addr);
        if (instr_req) chk("addr_align", {30'd0, instr_addr[1:0]}, 32'd0);
        if (!valid_if) chk("nop_out", instr_if, NOP);
        if (valid_if && !stall_if) begin
            chk("pc_seq", pc_if, exp_pc);
            chk("instr_data", instr_if, memf(exp_pc));
            exp_pc       = exp_pc + 32'd4;
            consumed_now = 1;
            consumed_pc  = pc_if;
            cons_log.push_back(pc_if);
            cons_total++;
        end
        if (redirect) exp_pc = redirect_target & 32'hFFFF_FFFC;
        if (instr_rvalid) begin
            memq.delete(0);
            resp_total++;
        end
        if (instr_req && instr_gnt) begin
            lat = $urandom_range(lat_min, lat_max);
            rdy = cyc_n + lat;
            if (rdy <= last_ready) rdy = last_ready + 1;
            last_ready = rdy;
            memq.push_back('{instr_addr, rdy});
            grant_log.push_back(instr_addr);
        end
        prev_req  = instr_req;
        prev_gnt  = instr_gnt;
        prev_addr = instr_addr;
    endtask

    task automatic wait_consume(input int budget, output bit ok);
        ok = 0;
        for (int i = 0; i < budget && !ok; i++) begin
            cyc();
            if (consumed_now) ok = 1;
        end
    endtask

    task automatic check_reset_outputs(input string phase);
        chk({phase, "_req"},   instr_req, 32'd0);
        chk({phase, "_valid"}, valid_if,  32'd0);
        chk({phase, "_instr"}, instr_if,  NOP);
        chk({phase, "_pc"},    pc_if,     32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        bit          ok;
        int          inflight, max_inflight, cons_before;
        logic [31:0] hold_pc, hold_instr, a0, t;
        logic [31:0] targets[2];

        rst_n = 0; instr_gnt = 0; instr_rvalid = 0; instr_rdata = 0;
        stall_if = 0; redirect = 0; redirect_target = 0;

        // Reset values
        drv_rst_n = 0;
        repeat (3) cyc();
        check_reset_outputs("rst");

        // Reset release, gnt tied high, 1-cycle response latency
        drv_rst_n = 1;
        grant_log.delete();
        cons_log.delete();
        cyc(); chk("c1_req", instr_req, 32'd0);
        cyc(); chk("c2_req", instr_req, 32'd1); chk("c2_addr", instr_addr, 32'h0);
        cyc(); chk("c3_req", instr_req, 32'd1); chk("c3_addr", instr_addr, 32'h4);
`ifdef IF_BYPASS_EN
        chk("first_valid_c3", valid_if, 32'd1);
`else
        chk("first_valid_c3", valid_if, 32'd0);
`endif
        cyc(); chk("c4_valid", valid_if, 32'd1);
        repeat (8) cyc();
        chk("grant_cnt", grant_log.size() >= 3, 32'd1);
        chk("cons_cnt",  cons_log.size() >= 3,  32'd1);
        for (int i = 0; i < 3; i++) begin
            if (i < grant_log.size()) chk("grant_addr", grant_log[i], 32'(i * 4));
            if (i < cons_log.size())  chk("cons_pc",    cons_log[i],  32'(i * 4));
        end

        // Decode stall for 10 cycles
        drv_stall = 1;
        max_inflight = 0;
        hold_pc = 0;
        hold_instr = 0;
        for (int i = 0; i < 10; i++) begin
            cyc();
            inflight = memq.size() + resp_total - cons_total;
            if (inflight > max_inflight) max_inflight = inflight;
            if (i == 3) begin
                hold_pc    = pc_if;
                hold_instr = instr_if;
            end
        end
        chk("stall_fill",       32'(max_inflight), 32'(DEPTH));
        chk("stall_valid",      valid_if,   32'd1);
        chk("stall_pc_hold",    pc_if,      hold_pc);
        chk("stall_instr_hold", instr_if,   hold_instr);
        drv_stall = 0;
        cons_before = cons_total;
        repeat (10) cyc();
        chk("stall_drain", (cons_total - cons_before) >= 4, 32'd1);

        // Grant withheld
        gnt_pct = 0;
        cyc(); a0 = instr_addr;
        cyc(); chk("nognt_addr1", instr_addr, a0);
        cyc(); chk("nognt_addr2", instr_addr, a0);
        cyc(); chk("nognt_addr3", instr_addr, a0); chk("nognt_req", instr_req, 32'd1);
        gnt_pct = 100;

        // Redirect to 0x103 with two requests outstanding
        lat_min = 4; lat_max = 4;
        ok = 0;
        for (int i = 0; i < 20 && !ok; i++) begin
            cyc();
            if (memq.size() == 2) ok = 1;
        end
        chk("redir_setup", ok, 32'd1);
        drv_redirect = 1; drv_target = 32'h103;
        grant_log.delete();
        cyc(); chk("redir_req", instr_req, 32'd0); chk("redir_valid", valid_if, 32'd0);
        drv_redirect = 0;
        cyc(); chk("redir_addr", instr_addr, 32'h100);
        wait_consume(40, ok);
        chk("redir_seen", ok, 32'd1);
        chk("redir_first_pc", consumed_pc, 32'h100);
        chk("redir_first_grant", (grant_log.size() > 0) ? grant_log[0] : 32'hFFFF_FFFF, 32'h100);

        // Redirect coinciding with gnt and rvalid; second target wraps
        lat_min = 1; lat_max = 1;
        targets[0] = 32'h0000_2002;
        targets[1] = 32'hFFFF_FFF8;
        for (int k = 0; k < 2; k++) begin
            t  = targets[k];
            ok = 0;
            for (int i = 0; i < 20 && !ok; i++) begin
                if (memq.size() > 0 && memq[0].ready <= cyc_n + 1) begin
                    drv_redirect = 1; drv_target = t;
                    cyc();
                    drv_redirect = 0;
                    chk("coincide_rvalid", instr_rvalid, 32'd1);
                    chk("coincide_gnt",    instr_gnt,    32'd1);
                    chk("coincide_valid",  valid_if,     32'd0);
                    ok = 1;
                end else begin
                    cyc();
                end
            end
            chk("coincide_setup", ok, 32'd1);
            for (int j = 0; j < 3; j++) begin
                wait_consume(40, ok);
                chk("coincide_seen", ok, 32'd1);
                chk("coincide_pc", consumed_pc, (t & 32'hFFFF_FFFC) + 32'(j * 4));
            end
        end

        // Random gnt / latency / stall / redirect against the PC model
        gnt_pct = 70; lat_min = 1; lat_max = 3;
        cons_before = cons_total;
        for (int i = 0; i < 3000; i++) begin
            drv_stall    = ($urandom_range(0, 99) < 30);
            drv_redirect = ($urandom_range(0, 99) < 3);
            drv_target   = $urandom();
            cyc();
        end
        drv_stall = 0; drv_redirect = 0; gnt_pct = 100;
        repeat (10) cyc();
        chk("random_progress", (cons_total - cons_before) > 200, 32'd1);

        // Reset in the middle of traffic
        lat_min = 3; lat_max = 3;
        repeat (3) cyc();
        drv_rst_n = 0;
        cyc();
        check_reset_outputs("midrst");
        drv_rst_n = 1;
        cyc(); chk("midrst_c1_req", instr_req, 32'd0);
        cyc(); chk("midrst_c2_req", instr_req, 32'd1); chk("midrst_c2_addr", instr_addr, 32'h0);
        wait_consume(40, ok);
        chk("midrst_seen", ok, 32'd1);
        chk("midrst_first_pc", consumed_pc, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
